// File: rtl/slave_rr_arbiter.sv
// Round-robin arbiter granting one master at a time access to a slave,
// with ack completion, request-drop abort and hold-time timeout.
module slave_rr_arbiter #(
    parameter int QTY_OF_MASTERS = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [QTY_OF_MASTERS-1:0]         request,
    input  logic                              ack,
    output logic [QTY_OF_MASTERS-1:0]         grant,
    output logic [$clog2(QTY_OF_MASTERS)-1:0] grant_id,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout
);

    localparam int IW = $clog2(QTY_OF_MASTERS);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    logic [0:0]    state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;

    logic [IW-1:0] winner;
    logic          found;
    logic [IW-1:0] next_ptr;

    // Search upward from ptr; index arithmetic wraps because N is a power of two.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < QTY_OF_MASTERS; i++) begin
            logic [IW-1:0] idx;
            idx = ptr + IW'(i);
            if (!found && request[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign next_ptr = grant_id + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (found) begin
                    state    <= BUSY;
                    cnt      <= '0;
                    busy     <= 1'b1;
                    grant_id <= winner;
                    grant    <= QTY_OF_MASTERS'(1) << winner;
                end
            end else begin
                // Exit priority: ack, then timeout, then abort.
                if (ack || cnt == CNT_LAST || !request[grant_id]) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                    ptr   <= next_ptr;
                    if (ack) begin
                        done <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                    end
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_slave_rr_arbiter.sv
// Directed self-checking bench for slave_rr_arbiter (4 masters, timeout 16).
module tb_slave_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] request;
    logic       ack;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       done;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    slave_rr_arbiter #(.QTY_OF_MASTERS(4), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .request  (request),
        .ack      (ack),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g,
                           input logic b, input logic d, input logic t);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    logic [3:0] seq [5];

    initial begin
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;
        rst = 1'b1; request = 4'b0000; ack = 1'b0;
        step(); step();
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("reset.grant_id", 32'(grant_id), 32'd0);
        rst = 1'b0;
        step();
        chk_all("idle_noreq", 4'b0000, 1'b0, 1'b0, 1'b0);

        // basic grant and ack completion
        request = 4'b1010;
        step();
        chk_all("g1", 4'b0010, 1'b1, 1'b0, 1'b0);
        chk("g1.grant_id", 32'(grant_id), 32'd1);
        ack = 1'b1;
        step();
        chk_all("g1_ack", 4'b0000, 1'b0, 1'b1, 1'b0);
        ack = 1'b0; request = 4'b0000;
        step();
        chk_all("g1_after", 4'b0000, 1'b0, 1'b0, 1'b0);
        request = 4'b0110;
        step();
        chk("ptr2.grant", 32'(grant), 32'(4'b0100));
        request = 4'b0000;
        step(); step();

        rst = 1'b1; step(); rst = 1'b0;

        // fairness with all masters requesting
        request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rr%0d", k), 32'(grant), 32'(seq[k]));
            step();
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk_all($sformatf("rr%0d_rel", k), 4'b0000, 1'b0, 1'b1, 1'b0);
        end
        request = 4'b0000;
        step();

        // timeout on master 2, others requesting do not disturb it
        request = 4'b0100;
        step();
        chk("to.first", 32'(grant), 32'(4'b0100));
        request = 4'b1110;
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("to.hold%0d", k), 32'(grant), 32'(4'b0100));
        end
        request = 4'b0000;
        step();
        chk_all("to.exit", 4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("to.after", 4'b0000, 1'b0, 1'b0, 1'b0);

        // ack on the last allowed cycle wins over timeout; ptr wraps to 0
        request = 4'b1000;
        step();
        chk("wrap.grant", 32'(grant), 32'(4'b1000));
        for (int k = 1; k < 16; k++) step();
        ack = 1'b1;
        step();
        chk_all("wrap.ack", 4'b0000, 1'b0, 1'b1, 1'b0);
        ack = 1'b0; request = 4'b1111;
        step();
        chk("wrap.next", 32'(grant), 32'(4'b0001));
        request = 4'b0000;
        step(); step();

        // abort by dropped request; ack in idle ignored
        request = 4'b0010;
        step();
        chk("ab.grant", 32'(grant), 32'(4'b0010));
        request = 4'b0000;
        step();
        chk_all("ab.exit", 4'b0000, 1'b0, 1'b0, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_all("ab.idle_ack", 4'b0000, 1'b0, 1'b0, 1'b0);

        // reset while busy, then search restarts at master 0
        request = 4'b0100;
        step();
        chk("rb.grant", 32'(grant), 32'(4'b0100));
        rst = 1'b1;
        step();
        chk_all("rb.reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("rb.grant_id", 32'(grant_id), 32'd0);
        rst = 1'b0; request = 4'b0000;
        step();
        request = 4'b0100;
        step();
        chk("rb.regrant", 32'(grant), 32'(4'b0100));
        chk("rb.regrant_id", 32'(grant_id), 32'd2);
        request = 4'b0000;
        step(); step();
        request = 4'b1010;
        step();
        chk("rb.ptr", 32'(grant), 32'(4'b1000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/slave_rr_arbiter.md
SLAVE_RR_ARBITER -- requirements
Module: slave_rr_arbiter

Interface
REQ-001 Parameter QTY_OF_MASTERS, default 4, number of masters competing for this slave; SHALL be a power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 16, maximum grant duration in cycles without slave ack; SHALL be at least 2.
REQ-003 clk  input  1  single clock, all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 request  input  QTY_OF_MASTERS  bit i = request from master i, as decoded by the master request listener for this slave.
REQ-006 ack  input  1  slave transaction-complete strobe, one cycle.
REQ-007 grant  output  QTY_OF_MASTERS  one-hot (or zero) grant to masters.
REQ-008 grant_id  output  $clog2(QTY_OF_MASTERS)  index of granted master, valid while busy=1.
REQ-009 busy  output  1  slave currently owned by a master.
REQ-010 done  output  1  one-cycle pulse, transaction completed by ack.
REQ-011 timeout  output  1  one-cycle pulse, grant revoked by timeout.

Function
REQ-012 All outputs SHALL be registered; grant SHALL be zero or one-hot in every cycle.
REQ-013 States SHALL be IDLE and BUSY; internal round-robin pointer ptr (width $clog2(QTY_OF_MASTERS)) and hold counter cnt (width $clog2(TIMEOUT+1)).
REQ-014 IDLE: when request is non-zero, the next cycle SHALL enter BUSY granting the first set request bit searched from ptr upward, wrapping modulo QTY_OF_MASTERS; grant latency one cycle.
REQ-015 IDLE with request zero: SHALL stay IDLE; grant=0, busy=0.
REQ-016 Entering BUSY SHALL load cnt=0, set busy=1, grant_id=winner, grant bit winner=1.
REQ-017 BUSY: cnt SHALL increment by 1 each cycle the grant is held, saturating at TIMEOUT.
REQ-018 BUSY with ack=1: next cycle SHALL return to IDLE, grant=0, done=1 for one cycle.
REQ-019 BUSY with request[grant_id]=0 and ack=0: next cycle SHALL return to IDLE (abort), done=0, timeout=0.
REQ-020 BUSY with ack=0 and cnt=TIMEOUT-1: next cycle SHALL return to IDLE with timeout=1 for one cycle; grant held exactly TIMEOUT cycles.
REQ-021 Priority of simultaneous BUSY exit events: ack over timeout over abort; only one of done/timeout SHALL ever pulse.
REQ-022 On every BUSY->IDLE transition ptr SHALL become (grant_id+1) modulo QTY_OF_MASTERS; ptr SHALL not change otherwise.
REQ-023 After any release the block SHALL spend at least one cycle in IDLE with grant=0 (bus turnaround) before a new grant.
REQ-024 ack in IDLE SHALL be ignored: no state change, no done pulse.
REQ-025 Requests from non-granted masters during BUSY SHALL not affect grant, cnt or ptr.
REQ-026 Fairness: with all masters requesting continuously, grants SHALL visit each master exactly once per QTY_OF_MASTERS grants.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, ptr=0, cnt=0, grant=0, grant_id=0, busy=0, done=0, timeout=0, overriding all other inputs.
REQ-028 rst asserted during BUSY SHALL drop grant the following cycle with no done or timeout pulse.
REQ-029 First arbitration after reset SHALL start search at master 0.

Verification
REQ-030 After reset, request=4'b1010 -> next cycle grant=4'b0010, grant_id=1, busy=1; ack pulse -> next cycle grant=0, done=1, ptr=2.
REQ-031 request=4'b1111 held, ack every third cycle -> grant sequence 0,1,2,3,0 with one idle cycle between grants.
REQ-032 grant to master 2, no ack, request held -> grant held exactly 16 cycles, then grant=0, timeout=1 one cycle, done=0.
REQ-033 grant to master 3, ack and cnt=TIMEOUT-1 in same cycle -> done=1, timeout=0; next grant searches from master 0 (wrap-around).
REQ-034 grant to master 1, request[1] dropped -> next cycle grant=0, done=0, timeout=0; ack in following IDLE cycle -> no done pulse.
REQ-035 rst=1 while busy with grant=4'b0100 -> next cycle all outputs zero; request=4'b0100 then -> grant master 2 from ptr=0 search.
